arb_mux: RTL and testbench

Registered, handshaked N-channel multiplexer that succeeds the fixed-select mux2/mux4/mux8 family. It arbitrates among NCH valid/ready input streams of WIDTH bits, with round-robin or fixed-priority selection chosen at run time. The winning word is forwarded through one output register stage. It sits between parallel DSP datapath lanes and a shared downstream consumer (accumulator, output buffer), replacing hand-driven `sel` lines with self-scheduling arbitration.

---
 rtl/arb_mux_pkg.sv | 8 +
 rtl/arb_mux_rr_arbiter.sv | 38 +++
 rtl/arb_mux.sv | 62 ++++++
 tb/tb_arb_mux.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrated N-channel multiplexer.
// Mode encodings are used by the top level and the arbiter.
package arb_mux_pkg;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_PRIO = 1'b1;

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: round-robin from ptr or fixed priority.
// Produces one-hot and binary grants plus an any-request flag.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  logic            found;
  logic [SELW-1:0] idx;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NCH; k++) begin
      // Priority mode scans from 0; round-robin scans from ptr.
      idx = (mode == MODE_PRIO) ? SELW'(k)
                                : SELW'((int'(ptr) + k) % NCH);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant = NCH'(found) << grant_idx;
  assign any   = |req;

endmodule

// File: rtl/arb_mux.sv
// Registered valid/ready N-channel mux with run-time selectable
// round-robin or fixed-priority arbitration.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0] rr_ptr;
  logic [NCH-1:0]  grant;
  logic [SELW-1:0] grant_idx;
  logic            any;
  logic            can_load;
  logic            take;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .mode      (mode),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign can_load = !out_valid || out_ready;
  assign in_ready = (can_load && any && !reset) ? grant : '0;
  assign take     = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (take) begin
      out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel   <= grant_idx;
      out_valid <= 1'b1;
      rr_ptr    <= (grant_idx == SELW'(NCH-1)) ? '0
                                               : grant_idx + SELW'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed self-checking bench for arb_mux (NCH=4, WIDTH=32).
// Inputs change #1 after posedge; outputs are checked before the next edge.
module tb_arb_mux;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mode;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words();
    in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode = 1'b0; in_valid = '0; out_ready = 1'b0; set_words();
    tick();
    for (int c = 0; c < 3; c++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = 4'($urandom);
      mode      = 1'($urandom);
      out_ready = 1'($urandom);
      #1;
      checks++;
      if (in_ready !== 4'b0) begin errors++;
        $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++;
        $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++;
      if (out_data !== 32'h0) begin errors++;
        $display("FAIL reset_data got %h exp 0", out_data); end
      checks++;
      if (out_sel !== 2'd0) begin errors++;
        $display("FAIL reset_sel got %0d exp 0", out_sel); end
    end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin errors++;
      $display("FAIL reset_ptr got %0d exp 0", dut.rr_ptr); end
    reset = 1'b0; in_valid = '0; out_ready = 1'b1; mode = 1'b0;
    set_words();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] es;
    mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      es = 2'(k % 4);
      #1;
      checks++;
      if (in_ready !== (4'b1 << es)) begin errors++;
        $display("FAIL rr_ready[%0d] got %b exp %b", k, in_ready, 4'b1 << es); end
      tick();
      checks++;
      if (out_sel !== es || out_valid !== 1'b1) begin errors++;
        $display("FAIL rr_sel[%0d] got %0d/%b exp %0d/1", k, out_sel, out_valid, es); end
      checks++;
      if (out_data !== 32'hA0 + 32'(es)) begin errors++;
        $display("FAIL rr_data[%0d] got %h exp %h", k, out_data, 32'hA0 + 32'(es)); end
    end
  endtask

  task automatic test_backpressure();
    tick();
    checks++;
    if (out_data !== 32'hA2 || dut.rr_ptr !== 2'd3) begin errors++;
      $display("FAIL bp_load got %h/%0d exp a2/3", out_data, dut.rr_ptr); end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0) begin errors++;
        $display("FAIL bp_ready[%0d] got %b exp 0000", c, in_ready); end
      tick();
      checks++;
      if (out_data !== 32'hA2 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d] got %h/%0d/%b exp a2/2/1", c, out_data, out_sel, out_valid); end
      checks++;
      if (dut.rr_ptr !== 2'd3) begin errors++;
        $display("FAIL bp_ptr[%0d] got %0d exp 3", c, dut.rr_ptr); end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin errors++;
      $display("FAIL bp_release_ready got %b exp 1000", in_ready); end
    tick();
    checks++;
    if (out_sel !== 2'd3 || out_data !== 32'hA3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got %0d/%h/%b exp 3/a3/1", out_sel, out_data, out_valid); end
  endtask

  task automatic test_priority();
    mode = 1'b1; in_valid = 4'b1110; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin errors++;
        $display("FAIL prio_ready[%0d] got %b exp 0010", c, in_ready); end
      tick();
      checks++;
      if (out_sel !== 2'd1 || out_data !== 32'hA1) begin errors++;
        $display("FAIL prio_out[%0d] got %0d/%h exp 1/a1", c, out_sel, out_data); end
    end
    checks++;
    if (dut.rr_ptr !== 2'd2) begin errors++;
      $display("FAIL prio_ptr got %0d exp 2", dut.rr_ptr); end
  endtask

  task automatic test_sparse_wrap();
    mode = 1'b0; in_valid = 4'b0100;
    tick();
    checks++;
    if (dut.rr_ptr !== 2'd3 || out_sel !== 2'd2) begin errors++;
      $display("FAIL sparse_setup got %0d/%0d exp 3/2", dut.rr_ptr, out_sel); end
    in_valid = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin errors++;
      $display("FAIL sparse_ready got %b exp 0010", in_ready); end
    tick();
    checks++;
    if (out_sel !== 2'd1 || out_data !== 32'hA1 || dut.rr_ptr !== 2'd2) begin
      errors++;
      $display("FAIL sparse_grant got %0d/%h/%0d exp 1/a1/2", out_sel, out_data, dut.rr_ptr); end
    in_valid = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0) begin errors++;
        $display("FAIL idle_ready[%0d] got %b exp 0000", c, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b0 || dut.rr_ptr !== 2'd2) begin errors++;
        $display("FAIL idle_drain[%0d] got %b/%0d exp 0/2", c, out_valid, dut.rr_ptr); end
      checks++;
      if (out_data !== 32'hA1 || out_sel !== 2'd1) begin errors++;
        $display("FAIL idle_hold[%0d] got %h/%0d exp a1/1", c, out_data, out_sel); end
    end
  endtask

  task automatic test_mode_switch();
    mode = 1'b0; in_valid = 4'b1001;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin errors++;
      $display("FAIL mode_rr_ready got %b exp 1000", in_ready); end
    mode = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++;
      $display("FAIL mode_prio_ready got %b exp 0001", in_ready); end
    tick();
    checks++;
    if (out_sel !== 2'd0 || dut.rr_ptr !== 2'd1) begin errors++;
      $display("FAIL mode_switch got %0d/%0d exp 0/1", out_sel, dut.rr_ptr); end
  endtask

  task automatic test_reset_mid_stall();
    mode = 1'b0; in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    in_valid = 4'hF; out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA2) begin errors++;
      $display("FAIL stall_setup got %b/%h exp 1/a2", out_valid, out_data); end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0) begin errors++;
      $display("FAIL rst_stall_ready got %b exp 0000", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || dut.rr_ptr !== 2'd0) begin errors++;
      $display("FAIL rst_stall got %b/%0d exp 0/0", out_valid, dut.rr_ptr); end
    reset = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++;
      $display("FAIL rst_first_ready got %b exp 0001", in_ready); end
    tick();
    checks++;
    if (out_sel !== 2'd0 || out_data !== 32'hA0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_first got %0d/%h/%b exp 0/a0/1", out_sel, out_data, out_valid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_priority();
    test_sparse_wrap();
    test_mode_switch();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
